uart_tx_fsm: RTL and testbench

//   Transmit-side counterpart of the UART receive control FSM. Serialises one byte

---
 rtl/uart_tx_fsm.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmit control FSM: serialises one byte as 8N1/8E1 with 1 or 2 stop bits.
// Starts on the level "send" bit and pulses clr_send_o once the frame has completed.
module uart_tx_fsm #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       send_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       clr_send_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);
  localparam bit PAR_ON   = (PARITY_EN != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             tx_d, busy_d, clr_d;
  logic             bit_end;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        // Capture the byte as send is sampled; later data changes cannot leak in.
        if (send_i) begin
          data_d  = tx_data_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        par_d   = ^data_q;
        cnt_d   = CNT_RELOAD;
        idx_d   = '0;
        stop_d  = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = CNT_RELOAD;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = PAR_ON ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = CNT_RELOAD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!TWO_STOP || stop_q) begin
            state_d = DONE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    clr_d  = 1'b0;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      LOAD:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_d[idx_d];
      PARITY:  tx_d   = par_d;
      DONE:    clr_d  = 1'b1;
      default: tx_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      data_q     <= '0;
      par_q      <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      clr_send_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      data_q     <= data_d;
      par_q      <= par_d;
      tx_o       <= tx_d;
      busy_o     <= busy_d;
      clr_send_o <= clr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: 8N1 instance plus an 8E2 instance, 16 clocks per bit.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       send_a, send_b;
  logic       tx_a, busy_a, clr_a;
  logic       tx_b, busy_b, clr_b;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_fsm #(
    .CLK_FREQ (1600),
    .BAUD     (100),
    .PARITY_EN(0),
    .STOP_BITS(1)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_data_i (data_a),
    .send_i    (send_a),
    .tx_o      (tx_a),
    .busy_o    (busy_a),
    .clr_send_o(clr_a)
  );

  uart_tx_fsm #(
    .CLK_FREQ (1600),
    .BAUD     (100),
    .PARITY_EN(1),
    .STOP_BITS(2)
  ) u_dut_par (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_data_i (data_b),
    .send_i    (send_b),
    .tx_o      (tx_b),
    .busy_o    (busy_b),
    .clr_send_o(clr_b)
  );

  // Expected {tx, busy, clr} k clocks after send is first sampled-ready (send driven before edge 1).
  function automatic logic [2:0] exp_vec(input int k, input logic [7:0] b, input int par_en,
                                         input int stops);
    int nb;
    int done_k;
    int slot;
    nb     = 1 + 8 + par_en + stops;
    done_k = 2 + nb * 16;
    if (k < 2 || k > done_k) return 3'b100;
    if (k == done_k) return 3'b111;
    slot = (k - 2) / 16;
    if (slot == 0) return 3'b010;
    if (slot <= 8) return {b[slot-1], 2'b10};
    if (par_en != 0 && slot == 9) return {^b, 2'b10};
    return 3'b110;
  endfunction

  task automatic test_reset();
    rst    = 1'b1;
    send_a = 1'b0;
    send_b = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({tx_a, busy_a, clr_a} !== 3'b100) begin
      err_cnt++;
      $display("FAIL reset_a: got %b want 100", {tx_a, busy_a, clr_a});
    end
    cmp_cnt++;
    if ({tx_b, busy_b, clr_b} !== 3'b100) begin
      err_cnt++;
      $display("FAIL reset_b: got %b want 100", {tx_b, busy_b, clr_b});
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      cmp_cnt++;
      if ({tx_a, busy_a, clr_a} !== 3'b100) begin
        err_cnt++;
        $display("FAIL idle_after_reset: got %b want 100", {tx_a, busy_a, clr_a});
      end
    end
  endtask

  // Single frame on the 8N1 instance; optionally change data after the LOAD edge.
  task automatic test_frame(input logic [7:0] b, input logic [7:0] late_data);
    int busy_n;
    int clr_n;
    logic [2:0] e;
    busy_n = 0;
    clr_n  = 0;
    @(negedge clk);
    data_a = b;
    send_a = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) send_a = 1'b0;
      if (k == 2) data_a = late_data;
      e = exp_vec(k, b, 0, 1);
      if (busy_a === 1'b1) busy_n++;
      if (clr_a === 1'b1) clr_n++;
      cmp_cnt++;
      if ({tx_a, busy_a, clr_a} !== e) begin
        err_cnt++;
        $display("FAIL frame_%h k=%0d: got %b want %b", b, k, {tx_a, busy_a, clr_a}, e);
      end
    end
    cmp_cnt++;
    if (busy_n != 161) begin
      err_cnt++;
      $display("FAIL busy_len_%h: got %0d want 161", b, busy_n);
    end
    cmp_cnt++;
    if (clr_n != 1) begin
      err_cnt++;
      $display("FAIL clr_pulses_%h: got %0d want 1", b, clr_n);
    end
  endtask

  task automatic test_parity_two_stop();
    logic [2:0] e;
    int done_at;
    done_at = -1;
    @(negedge clk);
    data_b = 8'h07;
    send_b = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) send_b = 1'b0;
      if (clr_b === 1'b1 && done_at < 0) done_at = k;
      e = exp_vec(k, 8'h07, 1, 2);
      cmp_cnt++;
      if ({tx_b, busy_b, clr_b} !== e) begin
        err_cnt++;
        $display("FAIL par_frame k=%0d: got %b want %b", k, {tx_b, busy_b, clr_b}, e);
      end
    end
    cmp_cnt++;
    if (done_at != 194) begin
      err_cnt++;
      $display("FAIL par_frame_len: got %0d want 194", done_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int clr_n;
    clr_n = 0;
    @(negedge clk);
    data_a = 8'h55;
    send_a = 1'b1;
    for (int k = 1; k <= 335; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 100) data_a = 8'h81;
      if (k == 200) send_a = 1'b0;
      if (clr_a === 1'b1) clr_n++;
      if (k <= 163) e = exp_vec(k, 8'h55, 0, 1);
      else e = exp_vec(k - 163, 8'h81, 0, 1);
      cmp_cnt++;
      if ({tx_a, busy_a, clr_a} !== e) begin
        err_cnt++;
        $display("FAIL b2b k=%0d: got %b want %b", k, {tx_a, busy_a, clr_a}, e);
      end
    end
    cmp_cnt++;
    if (clr_n != 2) begin
      err_cnt++;
      $display("FAIL b2b_clr_pulses: got %0d want 2", clr_n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int clr_n;
    clr_n = 0;
    @(negedge clk);
    data_a = 8'hF0;
    send_a = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) send_a = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if ({tx_a, busy_a, clr_a} !== 3'b100) begin
      err_cnt++;
      $display("FAIL mid_reset: got %b want 100", {tx_a, busy_a, clr_a});
    end
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
      if (clr_a === 1'b1) clr_n++;
    end
    cmp_cnt++;
    if (clr_n != 0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_quiet: got clr=%0d tx=%b busy=%b want 0 1 0", clr_n, tx_a,
               busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 8'hA5);
    test_frame(8'h3C, 8'hFF);
    test_parity_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame(8'hC3, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
